sparc_muldiv_unit: RTL and testbench

Parametrised, multi-cycle multiply/divide unit implementing SPARC UMUL/SMUL/UDIV/SDIV and their cc-setting variants, with Y-register semantics. It replaces single-cycle `*` and `/` in the execute stage with a radix-2 iterative datapath. The decoder diverts mul/div op3 codes here, with operand B already muxed between the register value and the sign-extended simm13. The execute stage stalls on `MDU_ready_out`, and results return to writeback with Y and icc write enables.

---
 rtl/sparc_mdu_pkg.sv | 39 +++
 rtl/mdu_fixup.sv | 67 ++++++
 rtl/sparc_muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_sparc_muldiv_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_mdu_pkg.sv
// Shared types and decode helpers for the SPARC multiply/divide unit.
package sparc_mdu_pkg;

  typedef enum logic [1:0] {
    OP_UMUL = 2'b00,
    OP_SMUL = 2'b01,
    OP_UDIV = 2'b10,
    OP_SDIV = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  localparam int unsigned ICC_N = 3;
  localparam int unsigned ICC_Z = 2;
  localparam int unsigned ICC_V = 1;
  localparam int unsigned ICC_C = 0;

  // op3 0x0A/0x0B/0x0E/0x0F (+0x10 for cc variants) -> unit operation.
  function automatic mdu_op_e mdu_decode_op3(input logic [5:0] op3);
    mdu_op_e op;
    case (op3[3:0])
      4'hA:    op = OP_UMUL;
      4'hB:    op = OP_SMUL;
      4'hE:    op = OP_UDIV;
      default: op = OP_SDIV;
    endcase
    return op;
  endfunction

  function automatic logic mdu_op3_setcc(input logic [5:0] op3);
    return op3[4];
  endfunction

endpackage

// File: rtl/mdu_fixup.sv
// Sign restore, divide saturation and icc generation applied to the raw accumulator.
module mdu_fixup
  import sparc_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mdu_op_e              op_i,
  input  logic                 sign_i,
  input  logic                 ovf_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  output logic [WIDTH-1:0]     res_o,
  output logic [WIDTH-1:0]     y_o,
  output logic [3:0]           icc_o
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic               v;

  always_comb begin
    res_o = '0;
    y_o   = '0;
    v     = 1'b0;
    prod  = sign_i ? -acc_i : acc_i;
    quo   = acc_i[WIDTH-1:0];
    case (op_i)
      OP_UMUL, OP_SMUL: begin
        res_o = prod[WIDTH-1:0];
        y_o   = prod[2*WIDTH-1:WIDTH];
      end
      OP_UDIV: begin
        if (ovf_i) begin
          res_o = '1;
          v     = 1'b1;
        end else begin
          res_o = quo;
        end
      end
      OP_SDIV: begin
        if (sign_i) begin
          if (ovf_i || (quo > MIN_NEG)) begin
            res_o = MIN_NEG;
            v     = 1'b1;
          end else begin
            res_o = -quo;
          end
        end else begin
          if (ovf_i || quo[WIDTH-1]) begin
            res_o = MAX_POS;
            v     = 1'b1;
          end else begin
            res_o = quo;
          end
        end
      end
    endcase
    icc_o        = '0;
    icc_o[ICC_N] = res_o[WIDTH-1];
    icc_o[ICC_Z] = (res_o == '0);
    icc_o[ICC_V] = v;
    icc_o[ICC_C] = 1'b0;
  end

endmodule

// File: rtl/sparc_muldiv_unit.sv
// Iterative radix-2 SPARC UMUL/SMUL/UDIV/SDIV unit with Y and icc results.
module sparc_muldiv_unit
  import sparc_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             MDU_clk_in,
  input  logic             MDU_reset_n_in,
  input  logic             MDU_valid_in,
  output logic             MDU_ready_out,
  input  logic [1:0]       MDU_op_in,
  input  logic             MDU_setcc_in,
  input  logic [WIDTH-1:0] MDU_valA_in,
  input  logic [WIDTH-1:0] MDU_valB_in,
  input  logic [WIDTH-1:0] MDU_y_in,
  input  logic             MDU_flush_in,
  output logic             MDU_valid_out,
  output logic [WIDTH-1:0] MDU_res_out,
  output logic [WIDTH-1:0] MDU_y_out,
  output logic             MDU_y_we_out,
  output logic [3:0]       MDU_icc_out,
  output logic             MDU_icc_we_out,
  output logic             MDU_div_zero_out
);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_q, op_d, op_in;
  logic               setcc_q, setcc_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               y_we_q, y_we_d;
  logic [3:0]         icc_q, icc_d;

  logic               is_div, a_neg, b_neg, dvd_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]     mul_sum, div_t, div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   fix_res, fix_y;
  logic [3:0]         fix_icc;

  mdu_fixup #(.WIDTH(WIDTH)) u_fixup (
    .op_i   (op_q),
    .sign_i (sign_q),
    .ovf_i  (ovf_q),
    .acc_i  (acc_q),
    .res_o  (fix_res),
    .y_o    (fix_y),
    .icc_o  (fix_icc)
  );

  // Operand magnitudes and the radix-2 step datapath.
  always_comb begin
    op_in   = mdu_op_e'(MDU_op_in);
    is_div  = MDU_op_in[1];
    a_neg   = (op_in == OP_SMUL) && MDU_valA_in[WIDTH-1];
    b_neg   = ((op_in == OP_SMUL) || (op_in == OP_SDIV)) && MDU_valB_in[WIDTH-1];
    dvd_neg = (op_in == OP_SDIV) && MDU_y_in[WIDTH-1];
    a_mag   = a_neg ? -MDU_valA_in : MDU_valA_in;
    b_mag   = b_neg ? -MDU_valB_in : MDU_valB_in;
    dvd_mag = dvd_neg ? -{MDU_y_in, MDU_valA_in} : {MDU_y_in, MDU_valA_in};

    // Shift-add: multiplier sits in the low half and is shifted out LSB first.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: partial remainder in the high half, quotient bits enter at the LSB.
    div_t    = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_t >= {1'b0, opb_q});
    div_sub  = div_t - {1'b0, opb_q};
    div_rem  = div_ge ? div_sub[WIDTH-1:0] : div_t[WIDTH-1:0];
    div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    setcc_d = setcc_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    y_d     = y_q;
    y_we_d  = y_we_q;
    icc_d   = icc_q;
    case (state_q)
      ST_IDLE: begin
        if (MDU_valid_in && !MDU_flush_in) begin
          op_d    = op_in;
          setcc_d = MDU_setcc_in;
          cnt_d   = '0;
          opb_d   = b_mag;
          if (is_div && (MDU_valB_in == '0)) begin
            state_d = ST_DONE;
            dz_d    = 1'b1;
            res_d   = '0;
            y_d     = '0;
            y_we_d  = 1'b0;
            icc_d   = '0;
          end else begin
            state_d = ST_CALC;
            dz_d    = 1'b0;
            if (is_div) begin
              acc_d  = dvd_mag;
              sign_d = dvd_neg ^ b_neg;
              ovf_d  = (dvd_mag[2*WIDTH-1:WIDTH] >= b_mag);
            end else begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              sign_d = a_neg ^ b_neg;
              ovf_d  = 1'b0;
            end
          end
        end
      end
      ST_CALC: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        res_d   = fix_res;
        y_d     = fix_y;
        y_we_d  = !op_q[1];
        icc_d   = fix_icc;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
    if (MDU_flush_in) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge MDU_clk_in or negedge MDU_reset_n_in) begin
    if (!MDU_reset_n_in) begin
      state_q <= ST_IDLE;
      op_q    <= OP_UMUL;
      setcc_q <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      y_q     <= '0;
      y_we_q  <= 1'b0;
      icc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      setcc_q <= setcc_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      y_q     <= y_d;
      y_we_q  <= y_we_d;
      icc_q   <= icc_d;
    end
  end

  always_comb begin
    MDU_ready_out    = (state_q == ST_IDLE);
    MDU_valid_out    = (state_q == ST_DONE) && !MDU_flush_in;
    MDU_res_out      = res_q;
    MDU_y_out        = y_q;
    MDU_y_we_out     = y_we_q && MDU_valid_out;
    MDU_icc_out      = icc_q;
    MDU_icc_we_out   = setcc_q && MDU_valid_out && !dz_q;
    MDU_div_zero_out = dz_q && MDU_valid_out;
  end

endmodule

// File: tb/tb_sparc_muldiv_unit.sv
module tb_sparc_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [1:0]  op_in = 2'b00;
  logic        setcc_in = 1'b0;
  logic [31:0] valA = '0;
  logic [31:0] valB = '0;
  logic [31:0] y_in = '0;
  logic        flush_in = 1'b0;
  logic        valid_out;
  logic [31:0] res_out;
  logic [31:0] y_out;
  logic        y_we_out;
  logic [3:0]  icc_out;
  logic        icc_we_out;
  logic        div_zero_out;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  sparc_muldiv_unit #(.WIDTH(32)) dut (
    .MDU_clk_in       (clk),
    .MDU_reset_n_in   (rst_n),
    .MDU_valid_in     (valid_in),
    .MDU_ready_out    (ready_out),
    .MDU_op_in        (op_in),
    .MDU_setcc_in     (setcc_in),
    .MDU_valA_in      (valA),
    .MDU_valB_in      (valB),
    .MDU_y_in         (y_in),
    .MDU_flush_in     (flush_in),
    .MDU_valid_out    (valid_out),
    .MDU_res_out      (res_out),
    .MDU_y_out        (y_out),
    .MDU_y_we_out     (y_we_out),
    .MDU_icc_out      (icc_out),
    .MDU_icc_we_out   (icc_we_out),
    .MDU_div_zero_out (div_zero_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural reference: full-width integer arithmetic, then SPARC saturation rules.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] y, output logic [31:0] r, output logic [31:0] yo,
                                output logic [3:0] icc, output logic ywe, output logic dz);
    logic [63:0] p;
    logic [63:0] uq;
    longint      sd, sb, q;
    logic        v;
    r = '0; yo = '0; ywe = 1'b0; dz = 1'b0; v = 1'b0;
    case (op)
      2'd0: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0]; yo = p[63:32]; ywe = 1'b1;
      end
      2'd1: begin
        sd = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sd * sb;
        p  = q;
        r = p[31:0]; yo = p[63:32]; ywe = 1'b1;
      end
      2'd2: begin
        if (b == 0) dz = 1'b1;
        else begin
          uq = {y, a} / {32'b0, b};
          if (uq > 64'h0000_0000_FFFF_FFFF) begin r = 32'hFFFF_FFFF; v = 1'b1; end
          else r = uq[31:0];
        end
      end
      default: begin
        if (b == 0) dz = 1'b1;
        else if (b == 32'hFFFF_FFFF && {y, a} == 64'h8000_0000_0000_0000) begin
          r = 32'h7FFF_FFFF; v = 1'b1;
        end else begin
          sd = $signed({y, a});
          sb = longint'($signed(b));
          q  = sd / sb;
          if (q > 64'sd2147483647) begin r = 32'h7FFF_FFFF; v = 1'b1; end
          else if (q < -64'sd2147483648) begin r = 32'h8000_0000; v = 1'b1; end
          else r = q[31:0];
        end
      end
    endcase
    icc = {r[31], (r == 32'b0), v, 1'b0};
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge one cycle after the result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic cc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] y);
    logic [31:0] er, ey;
    logic [3:0]  eicc;
    logic        ewe, edz;
    int unsigned lat, n;
    model(op, a, b, y, er, ey, eicc, ewe, edz);
    lat = edz ? 1 : 34;
    check({tag, "_ready_before"}, ready_out, 1);
    valid_in = 1'b1; op_in = op; setcc_in = cc; valA = a; valB = b; y_in = y;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0; op_in = 2'($urandom); setcc_in = 1'($urandom);
    valA = $urandom; valB = $urandom; y_in = $urandom;
    n = 1;
    while (!valid_out && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    last_res = res_out;
    check({tag, "_latency"}, n, lat);
    check({tag, "_res"}, res_out, er);
    if (ewe) check({tag, "_y"}, y_out, ey);
    check({tag, "_y_we"}, y_we_out, ewe);
    check({tag, "_dz"}, div_zero_out, edz);
    check({tag, "_icc_we"}, icc_we_out, cc & ~edz);
    if (!edz) check({tag, "_icc"}, icc_out, eicc);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_after"}, valid_out, 0);
    check({tag, "_ready_after"}, ready_out, 1);
  endtask

  initial begin
    int unsigned pulses;
    logic [1:0]  rop;
    logic [31:0] ra, rb, ry;

    #12;
    check("rst_ready", ready_out, 1);
    check("rst_valid", valid_out, 0);
    check("rst_res", res_out, 0);
    check("rst_y", y_out, 0);
    check("rst_y_we", y_we_out, 0);
    check("rst_icc", icc_out, 0);
    check("rst_icc_we", icc_we_out, 0);
    check("rst_dz", div_zero_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("umul_max", 2'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    check("umul_max_const", last_res, 32'h0000_0001);
    run_op("smul_neg", 2'd1, 1'b1, 32'd5, 32'hFFFF_FFFD, 32'h0);
    check("smul_neg_const", last_res, 32'hFFFF_FFF1);
    run_op("udiv_basic", 2'd2, 1'b1, 32'd100, 32'd7, 32'h0);
    check("udiv_basic_const", last_res, 32'd14);
    run_op("udiv_ovf", 2'd2, 1'b1, 32'h0, 32'd1, 32'h1);
    check("udiv_ovf_const", last_res, 32'hFFFF_FFFF);
    run_op("sdiv_neg", 2'd3, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFF);
    check("sdiv_neg_const", last_res, 32'hFFFF_FFF2);
    run_op("sdiv_posovf", 2'd3, 1'b1, 32'h8000_0000, 32'd1, 32'h0);
    check("sdiv_posovf_const", last_res, 32'h7FFF_FFFF);
    run_op("sdiv_minneg", 2'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    check("sdiv_minneg_const", last_res, 32'h8000_0000);
    run_op("udiv_zero", 2'd2, 1'b1, 32'd55, 32'd0, 32'h0);

    // Flush in cycle 10 of a multiply.
    valid_in = 1'b1; op_in = 2'd0; setcc_in = 1'b0; valA = 32'd9; valB = 32'd9; y_in = '0;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    flush_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_in = 1'b0;
    check("flush_ready_c11", ready_out, 1);
    pulses = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (valid_out) pulses++; end
    check("flush_no_pulse", pulses, 0);
    run_op("after_flush", 2'd0, 1'b0, 32'd3, 32'd4, 32'h0);
    check("after_flush_const", last_res, 32'd12);

    // Asynchronous reset mid-CALC.
    valid_in = 1'b1; op_in = 2'd1; setcc_in = 1'b1; valA = 32'd77; valB = 32'd3; y_in = '0;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1 check("areset_ready", ready_out, 1);
    check("areset_valid", valid_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (valid_out) pulses++; end
    check("areset_no_pulse", pulses, 0);
    run_op("after_reset", 2'd0, 1'b0, 32'd3, 32'd4, 32'h0);
    check("after_reset_const", last_res, 32'd12);

    // A request presented with flush is not accepted.
    valid_in = 1'b1; flush_in = 1'b1; op_in = 2'd0; valA = 32'd2; valB = 32'd2;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0; flush_in = 1'b0;
    check("flush_reject_ready", ready_out, 1);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case (rop)
        2'd2:    ry = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 5)) : $urandom;
        2'd3:    ry = ($urandom_range(0, 2) != 0) ? {32{ra[31]}} : $urandom;
        default: ry = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, 1'($urandom), ra, rb, ry);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
